// File: rtl/lsu_agu_s2.sv
// Load/store address generation, stage 2: computes the virtual address and alignment fault
// for each issued memory op and queues it in a 2-entry in-order FIFO for the LSU control unit.
module lsu_agu_s2 #(
    parameter int unsigned XLEN             = 64,
    parameter int unsigned VIRTUAL_ADDR_LEN = 39,
    parameter int unsigned ROB_TAG_W        = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,

    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic                        issue_opcode_i,
    input  logic [1:0]                  issue_size_i,
    input  logic [XLEN-1:0]             issue_base_i,
    input  logic [XLEN-1:0]             issue_imm_i,
    input  logic [XLEN-1:0]             issue_store_data_i,
    input  logic [ROB_TAG_W-1:0]        issue_rob_tag_i,

    output logic                        valid_o,
    output logic                        opcode_o,
    output logic [1:0]                  size_o,
    output logic [VIRTUAL_ADDR_LEN-1:0] addr_o,
    output logic [XLEN-1:0]             store_data_o,
    output logic [ROB_TAG_W-1:0]        rob_tag_o,
    output logic                        exception_valid_o,
    output logic [3:0]                  ecause_o,
    input  logic                        ls_done_i
);

    localparam logic [3:0] EcauseLoadMisaligned  = 4'd4;
    localparam logic [3:0] EcauseStoreMisaligned = 4'd6;

    typedef struct packed {
        logic                        opcode;
        logic [1:0]                  size;
        logic [VIRTUAL_ADDR_LEN-1:0] addr;
        logic [XLEN-1:0]             store_data;
        logic [ROB_TAG_W-1:0]        rob_tag;
        logic                        exception;
        logic [3:0]                  ecause;
    } entry_t;

    entry_t     entry_q [2];
    entry_t     entry_d [2];
    entry_t     new_entry;
    entry_t     head;

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    logic [XLEN-1:0] sum;
    logic            misaligned;
    logic            accept;
    logic            retire;

    // Only the low VIRTUAL_ADDR_LEN bits of the sum form the address.
    if (XLEN > VIRTUAL_ADDR_LEN) begin : g_sum_hi
        logic unused_sum_hi;
        assign unused_sum_hi = ^sum[XLEN-1:VIRTUAL_ADDR_LEN];
    end

    always_comb begin
        sum = issue_base_i + issue_imm_i;
        misaligned = 1'b0;
        unique case (issue_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = sum[0];
            2'd2:    misaligned = |sum[1:0];
            2'd3:    misaligned = |sum[2:0];
            default: misaligned = 1'b0;
        endcase

        new_entry.opcode     = issue_opcode_i;
        new_entry.size       = issue_size_i;
        new_entry.addr       = sum[VIRTUAL_ADDR_LEN-1:0];
        new_entry.store_data = issue_store_data_i;
        new_entry.rob_tag    = issue_rob_tag_i;
        new_entry.exception  = misaligned;
        if (!misaligned) begin
            new_entry.ecause = 4'd0;
        end else if (issue_opcode_i) begin
            new_entry.ecause = EcauseStoreMisaligned;
        end else begin
            new_entry.ecause = EcauseLoadMisaligned;
        end
    end

    assign issue_ready_o = (count_q != 2'd2);
    assign valid_o       = (count_q != 2'd0) && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o && !flush_i;
    assign retire        = valid_o && ls_done_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (retire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({accept, retire})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        if (accept) begin
            entry_d[wr_ptr_q] = new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload is qualified by valid_o, so it carries no reset.
    always_ff @(posedge clk) begin
        entry_q[0] <= entry_d[0];
        entry_q[1] <= entry_d[1];
    end

    assign head              = entry_q[rd_ptr_q];
    assign opcode_o          = head.opcode;
    assign size_o            = head.size;
    assign addr_o            = head.addr;
    assign store_data_o      = head.store_data;
    assign rob_tag_o         = head.rob_tag;
    assign exception_valid_o = valid_o && head.exception;
    assign ecause_o          = head.ecause;

endmodule

// File: tb/tb_lsu_agu_s2.sv
// Scoreboard bench for lsu_agu_s2: expected entries are queued at issue and compared against
// the head outputs while they are presented and when they retire.
module tb_lsu_agu_s2;

    typedef logic [115:0] ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic        issue_opcode_i = 1'b0;
    logic [1:0]  issue_size_i = 2'd0;
    logic [63:0] issue_base_i = '0;
    logic [63:0] issue_imm_i = '0;
    logic [63:0] issue_store_data_i = '0;
    logic [4:0]  issue_rob_tag_i = '0;
    logic        valid_o;
    logic        opcode_o;
    logic [1:0]  size_o;
    logic [38:0] addr_o;
    logic [63:0] store_data_o;
    logic [4:0]  rob_tag_o;
    logic        exception_valid_o;
    logic [3:0]  ecause_o;
    logic        ls_done_i = 1'b0;

    int   n_checks = 0;
    int   n_pass = 0;
    ent_t sb[$];
    int   tag_ctr = 0;

    lsu_agu_s2 dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_opcode_i    (issue_opcode_i),
        .issue_size_i      (issue_size_i),
        .issue_base_i      (issue_base_i),
        .issue_imm_i       (issue_imm_i),
        .issue_store_data_i(issue_store_data_i),
        .issue_rob_tag_i   (issue_rob_tag_i),
        .valid_o           (valid_o),
        .opcode_o          (opcode_o),
        .size_o            (size_o),
        .addr_o            (addr_o),
        .store_data_o      (store_data_o),
        .rob_tag_o         (rob_tag_o),
        .exception_valid_o (exception_valid_o),
        .ecause_o          (ecause_o),
        .ls_done_i         (ls_done_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: full 64-bit add, alignment by modulus of the access size.
    function automatic ent_t model(input logic op, input logic [1:0] sz, input logic [63:0] b,
                                   input logic [63:0] i, input logic [63:0] d,
                                   input logic [4:0] t);
        logic [63:0] s;
        logic        mis;
        logic [3:0]  ec;
        s   = b + i;
        mis = (s % (64'd1 << sz)) != 64'd0;
        ec  = mis ? (op ? 4'd6 : 4'd4) : 4'd0;
        return {op, sz, s[38:0], d, t, mis, ec};
    endfunction

    function automatic ent_t observed();
        return {opcode_o, size_o, addr_o, store_data_o, rob_tag_o, exception_valid_o, ecause_o};
    endfunction

    task automatic drive_issue(input logic op, input logic [1:0] sz, input logic [63:0] b,
                               input logic [63:0] i, output ent_t e);
        logic [63:0] d;
        d = {$urandom, $urandom};
        tag_ctr = tag_ctr + 1;
        issue_valid_i      = 1'b1;
        issue_opcode_i     = op;
        issue_size_i       = sz;
        issue_base_i       = b;
        issue_imm_i        = i;
        issue_store_data_i = d;
        issue_rob_tag_i    = tag_ctr[4:0];
        e = model(op, sz, b, i, d, tag_ctr[4:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ls_done_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o);
        else n_pass++;
        n_checks++;
        if (exception_valid_o !== 1'b0) $display("FAIL reset_exc: got %b expected 0", exception_valid_o);
        else n_pass++;
        n_checks++;
        if (issue_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", issue_ready_o);
        else n_pass++;
        // ls_done_i on an empty queue must be ignored.
        ls_done_i = 1'b1;
        tick();
        tick();
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL idle_done_valid: got %b expected 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_load_hold();
        ent_t e;
        drive_issue(1'b0, 2'd3, 64'h1000, 64'h8, e);
        sb.push_back(e);
        tick();
        issue_valid_i = 1'b0;
        n_checks++;
        if (addr_o !== 39'h1008) $display("FAIL load_addr: got %h expected 1008", addr_o);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (valid_o !== 1'b1 || observed() !== sb[0])
                $display("FAIL load_hold%0d: got v=%b %h expected v=1 %h", c, valid_o, observed(), sb[0]);
            else n_pass++;
            tick();
        end
        ls_done_i = 1'b1;
        tick();
        void'(sb.pop_front());
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL load_retire: got %b expected 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_misalign();
        logic        ops [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  szs [6] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 2'd1};
        logic [63:0] bas [6] = '{64'h1001, 64'h1003, 64'h1003, 64'h7, 64'h1004, 64'h1002};
        logic        exx [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  ecs [6] = '{4'd6, 4'd4, 4'd0, 4'd0, 4'd4, 4'd0};
        ent_t e;
        for (int k = 0; k < 6; k++) begin
            drive_issue(ops[k], szs[k], bas[k], 64'h0, e);
            sb.push_back(e);
            tick();
            issue_valid_i = 1'b0;
            n_checks++;
            if (exception_valid_o !== exx[k] || ecause_o !== ecs[k])
                $display("FAIL misalign%0d: got exc=%b cause=%0d expected exc=%b cause=%0d",
                         k, exception_valid_o, ecause_o, exx[k], ecs[k]);
            else n_pass++;
            ls_done_i = 1'b1;
            n_checks++;
            if (valid_o !== 1'b1 || observed() !== sb[0])
                $display("FAIL misalign_head%0d: got %h expected %h", k, observed(), sb[0]);
            else n_pass++;
            tick();
            void'(sb.pop_front());
            ls_done_i = 1'b0;
        end
    endtask

    task automatic test_addr_wrap();
        ent_t e;
        drive_issue(1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, e);
        sb.push_back(e);
        tick();
        issue_valid_i = 1'b0;
        n_checks++;
        if (addr_o !== 39'h8 || exception_valid_o !== 1'b0)
            $display("FAIL addr_wrap: got addr=%h exc=%b expected addr=8 exc=0", addr_o, exception_valid_o);
        else n_pass++;
        ls_done_i = 1'b1;
        tick();
        void'(sb.pop_front());
        ls_done_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        ent_t e;
        drive_issue(1'b0, 2'd2, 64'h2000, 64'h4, e);
        sb.push_back(e);
        tick();
        drive_issue(1'b1, 2'd3, 64'h3000, 64'h8, e);
        sb.push_back(e);
        tick();
        n_checks++;
        if (issue_ready_o !== 1'b0) $display("FAIL full_ready: got %b expected 0", issue_ready_o);
        else n_pass++;
        drive_issue(1'b0, 2'd0, 64'h4000, 64'h1, e);
        tick();
        issue_valid_i = 1'b0;
        n_checks++;
        if (issue_ready_o !== 1'b0 || observed() !== sb[0])
            $display("FAIL full_reject: got rdy=%b %h expected rdy=0 %h", issue_ready_o, observed(), sb[0]);
        else n_pass++;
        ls_done_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (valid_o !== 1'b1 || observed() !== sb[0])
                $display("FAIL b2b_order%0d: got v=%b %h expected v=1 %h", c, valid_o, observed(), sb[0]);
            else n_pass++;
            tick();
            void'(sb.pop_front());
        end
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || issue_ready_o !== 1'b1)
            $display("FAIL b2b_drain: got v=%b rdy=%b expected v=0 rdy=1", valid_o, issue_ready_o);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        ent_t e;
        drive_issue(1'b0, 2'd1, 64'h5000, 64'h2, e);
        sb.push_back(e);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive_issue(k[0], 2'(k), 64'h6000 + 64'(k * 16), 64'h0, e);
            ls_done_i = 1'b1;
            tick();
            void'(sb.pop_front());
            sb.push_back(e);
            n_checks++;
            if (valid_o !== 1'b1 || issue_ready_o !== 1'b1 || observed() !== sb[0])
                $display("FAIL simul%0d: got v=%b rdy=%b %h expected v=1 rdy=1 %h",
                         k, valid_o, issue_ready_o, observed(), sb[0]);
            else n_pass++;
        end
        issue_valid_i = 1'b0;
        tick();
        void'(sb.pop_front());
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL simul_drain: got %b expected 0", valid_o);
        else n_pass++;
    endtask

    task automatic test_flush_reset();
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            drive_issue(1'b0, 2'd0, 64'h7000 + 64'(k), 64'h0, e);
            tick();
        end
        drive_issue(1'b1, 2'd3, 64'h8000, 64'h0, e);
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL flush_same_cycle: got %b expected 0", valid_o);
        else n_pass++;
        tick();
        flush_i = 1'b0;
        issue_valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || issue_ready_o !== 1'b1)
            $display("FAIL flush_after: got v=%b rdy=%b expected v=0 rdy=1", valid_o, issue_ready_o);
        else n_pass++;
        drive_issue(1'b1, 2'd1, 64'h9000, 64'h2, e);
        tick();
        issue_valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b1 || observed() !== e)
            $display("FAIL flush_refill: got v=%b %h expected v=1 %h", valid_o, observed(), e);
        else n_pass++;
        drive_issue(1'b0, 2'd2, 64'hA000, 64'h0, e);
        tick();
        issue_valid_i = 1'b0;
        rst = 1'b1;
        ls_done_i = 1'b1;
        tick();
        rst = 1'b0;
        ls_done_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || issue_ready_o !== 1'b1 || exception_valid_o !== 1'b0)
            $display("FAIL reset_full: got v=%b rdy=%b exc=%b expected v=0 rdy=1 exc=0",
                     valid_o, issue_ready_o, exception_valid_o);
        else n_pass++;
    endtask

    task automatic test_random();
        ent_t e;
        logic iv, dn, fl, acc, ret;
        for (int c = 0; c < 200; c++) begin
            iv = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            if (iv) drive_issue(1'($urandom), 2'($urandom), {$urandom, $urandom},
                                64'($urandom_range(0, 15)), e);
            else issue_valid_i = 1'b0;
            ls_done_i = dn;
            flush_i = fl;
            #1;
            n_checks++;
            if (issue_ready_o !== (sb.size() != 2) || valid_o !== (sb.size() != 0 && !fl) ||
                (valid_o === 1'b1 && observed() !== sb[0]))
                $display("FAIL random%0d: got v=%b rdy=%b %h expected depth=%0d head=%h",
                         c, valid_o, issue_ready_o, observed(), sb.size(),
                         (sb.size() != 0) ? sb[0] : ent_t'(0));
            else n_pass++;
            acc = iv && (sb.size() != 2) && !fl;
            ret = dn && (sb.size() != 0) && !fl;
            tick();
            if (fl) sb.delete();
            else begin
                if (ret) void'(sb.pop_front());
                if (acc) sb.push_back(e);
            end
        end
        issue_valid_i = 1'b0;
        ls_done_i = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_misalign();
        test_addr_wrap();
        test_back_to_back();
        test_simultaneous();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
